ps2_keycode_decoder: RTL and testbench

- Sequential successor to the combinational English keycode lookup.
- Consumes PS/2 scan-code set 2 bytes from the PS/2 byte receiver.
- Tracks make/break/extended prefixes and shift and caps-lock state, then translates make codes to ASCII.
- Buffers characters in a parametrised first-word-fall-through FIFO with a valid/ready output toward the text/console logic.

---
 rtl/ps2_keycode_decoder_if.sv | 36 +++
 rtl/ps2_keycode_decoder.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_ps2_keycode_decoder.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_keycode_decoder_if.sv
// ---------------------------------------------------------------------------
// ps2_keycode_decoder_if
//   Groups the two streams of the PS/2 keycode decoder: the scan-code byte
//   stream coming from the PS/2 byte receiver and the character stream going
//   to the text/console logic.
//
//   Signals:
//     i_code      [7:0]        scan-code byte from the PS/2 receiver
//     i_code_vld               one-cycle strobe, i_code valid
//     o_char      [CHAR_W-1:0] FIFO head character, 0 when empty
//     o_char_vld               FIFO non-empty
//     i_char_rdy               consumer pops the head when o_char_vld is high
//
//   Modports:
//     master : environment side (drives codes, consumes characters)
//     slave  : decoder side
// ---------------------------------------------------------------------------
interface ps2_keycode_decoder_if #(
  parameter int CHAR_W = 8
);
  logic [7:0]        i_code;
  logic              i_code_vld;
  logic [CHAR_W-1:0] o_char;
  logic              o_char_vld;
  logic              i_char_rdy;

  modport master (
    output i_code, i_code_vld, i_char_rdy,
    input  o_char, o_char_vld
  );

  modport slave (
    input  i_code, i_code_vld, i_char_rdy,
    output o_char, o_char_vld
  );
endinterface

// File: rtl/ps2_keycode_decoder.sv
// ---------------------------------------------------------------------------
// ps2_keycode_decoder
//   Turns PS/2 scan-code set 2 bytes into ASCII characters.  A prefix FSM
//   tracks the E0 (extended) and F0 (break) prefixes, modifier state (left and
//   right shift, caps lock) is kept in flops, non-extended make codes are
//   translated to ASCII in a single decode register and then queued in a
//   first-word-fall-through FIFO with a valid/ready output.
//
//   Latency: byte strobed at edge k is in the decode register after edge k,
//   written into the FIFO at edge k+1.
//
//   Parameters:
//     CHAR_W     output character width (ASCII in [6:0], upper bits zero)
//     FIFO_DEPTH character FIFO entries, power of two, 2..64
//
//   Ports:
//     i_clk   system clock
//     i_rst   synchronous active-high reset
//     bus     code input / character output streams (slave modport)
//     o_shft  left or right shift currently held
//     o_caps  caps-lock latched state
//     o_ovf   one-cycle pulse, a decoded character was dropped (FIFO full)
//
//   Build option:
//     PS2_REPEAT_FILTER_EN  when defined, a make code identical to the last
//                           non-modifier make (same extended flag) with no
//                           break of that code in between emits nothing, so
//                           typematic repeat is suppressed.
// ---------------------------------------------------------------------------
module ps2_keycode_decoder #(
  parameter int CHAR_W     = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  ps2_keycode_decoder_if.slave   bus,
  output logic                   o_shft,
  output logic                   o_caps,
  output logic                   o_ovf
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } state_e;

  // Returns {hit, ascii[6:0]}; hit=0 means the key produces no character.
  function automatic logic [7:0] translate(input logic [7:0] code,
                                           input logic       ext,
                                           input logic       shft,
                                           input logic       caps);
    logic [6:0] lo;
    logic [6:0] hi;
    logic       hit;
    logic       letter;
    logic       sel_hi;
    lo  = 7'h00;
    hi  = 7'h00;
    hit = 1'b1;
    if (ext) begin
      // Keypad Enter is the only extended key that yields a character.
      hit = (code == 8'h5A);
      lo  = 7'h0D;
      hi  = 7'h0D;
    end else begin
      case (code)
        // letters (upper case derived below)
        8'h1C: lo = 7'h61;  8'h32: lo = 7'h62;  8'h21: lo = 7'h63;
        8'h23: lo = 7'h64;  8'h24: lo = 7'h65;  8'h2B: lo = 7'h66;
        8'h34: lo = 7'h67;  8'h33: lo = 7'h68;  8'h43: lo = 7'h69;
        8'h3B: lo = 7'h6A;  8'h42: lo = 7'h6B;  8'h4B: lo = 7'h6C;
        8'h3A: lo = 7'h6D;  8'h31: lo = 7'h6E;  8'h44: lo = 7'h6F;
        8'h4D: lo = 7'h70;  8'h15: lo = 7'h71;  8'h2D: lo = 7'h72;
        8'h1B: lo = 7'h73;  8'h2C: lo = 7'h74;  8'h3C: lo = 7'h75;
        8'h2A: lo = 7'h76;  8'h1D: lo = 7'h77;  8'h22: lo = 7'h78;
        8'h35: lo = 7'h79;  8'h1A: lo = 7'h7A;
        // digits
        8'h45: begin lo = 7'h30; hi = 7'h29; end
        8'h16: begin lo = 7'h31; hi = 7'h21; end
        8'h1E: begin lo = 7'h32; hi = 7'h40; end
        8'h26: begin lo = 7'h33; hi = 7'h23; end
        8'h25: begin lo = 7'h34; hi = 7'h24; end
        8'h2E: begin lo = 7'h35; hi = 7'h25; end
        8'h36: begin lo = 7'h36; hi = 7'h5E; end
        8'h3D: begin lo = 7'h37; hi = 7'h26; end
        8'h3E: begin lo = 7'h38; hi = 7'h2A; end
        8'h46: begin lo = 7'h39; hi = 7'h28; end
        // punctuation
        8'h0E: begin lo = 7'h60; hi = 7'h7E; end
        8'h4E: begin lo = 7'h2D; hi = 7'h5F; end
        8'h55: begin lo = 7'h3D; hi = 7'h2B; end
        8'h54: begin lo = 7'h5B; hi = 7'h7B; end
        8'h5B: begin lo = 7'h5D; hi = 7'h7D; end
        8'h5D: begin lo = 7'h5C; hi = 7'h7C; end
        8'h4C: begin lo = 7'h3B; hi = 7'h3A; end
        8'h52: begin lo = 7'h27; hi = 7'h22; end
        8'h41: begin lo = 7'h2C; hi = 7'h3C; end
        8'h49: begin lo = 7'h2E; hi = 7'h3E; end
        8'h4A: begin lo = 7'h2F; hi = 7'h3F; end
        // control keys are shift-insensitive
        8'h29: begin lo = 7'h20; hi = 7'h20; end
        8'h5A: begin lo = 7'h0D; hi = 7'h0D; end
        8'h66: begin lo = 7'h08; hi = 7'h08; end
        8'h0D: begin lo = 7'h09; hi = 7'h09; end
        8'h76: begin lo = 7'h1B; hi = 7'h1B; end
        default: hit = 1'b0;
      endcase
    end
    // Only letters land in 0x61..0x7A on the unshifted side.
    letter = (lo >= 7'h61) && (lo <= 7'h7A);
    if (letter) hi = lo - 7'h20;
    sel_hi = letter ? (shft ^ caps) : shft;
    return {hit, sel_hi ? hi : lo};
  endfunction

  // ---------------------------------------------------------------- decode
  state_e     state_q, state_d;
  logic       shft_l_q, shft_l_d;
  logic       shft_r_q, shft_r_d;
  logic       caps_q, caps_d;
  logic       caps_held_q, caps_held_d;
  logic       dec_vld_q, dec_vld_d;
  logic [6:0] dec_char_q, dec_char_d;

  logic       is_ext;
  logic       is_brk;
  logic       is_resp;
  logic [7:0] tr;
  logic       rep_hit;

`ifdef PS2_REPEAT_FILTER_EN
  logic       filt_vld_q, filt_vld_d;
  logic       filt_ext_q, filt_ext_d;
  logic [7:0] filt_code_q, filt_code_d;
  logic       filt_match;

  assign filt_match = filt_vld_q && (filt_code_q == bus.i_code) && (filt_ext_q == is_ext);
`endif

  assign is_ext  = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
  assign is_brk  = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);
  assign is_resp = bus.i_code inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
  assign tr      = translate(bus.i_code, is_ext, o_shft, caps_q);

  // NOTE: every signal driven here gets a default first so that no path
  // leaves it unassigned; that is what keeps this block free of latches.
  always_comb begin
    state_d     = state_q;
    shft_l_d    = shft_l_q;
    shft_r_d    = shft_r_q;
    caps_d      = caps_q;
    caps_held_d = caps_held_q;
    dec_vld_d   = 1'b0;
    dec_char_d  = dec_char_q;
    rep_hit     = 1'b0;
`ifdef PS2_REPEAT_FILTER_EN
    filt_vld_d  = filt_vld_q;
    filt_ext_d  = filt_ext_q;
    filt_code_d = filt_code_q;
`endif

    if (bus.i_code_vld) begin
      if (bus.i_code == 8'hE0) begin
        state_d = ST_EXT;
      end else if (bus.i_code == 8'hF0) begin
        case (state_q)
          ST_IDLE: state_d = ST_BRK;
          ST_EXT:  state_d = ST_EXT_BRK;
          default: state_d = state_q;
        endcase
      end else if (is_resp) begin
        state_d = ST_IDLE;
      end else begin
        state_d = ST_IDLE;
        // E0 12 / E0 59 are the keyboard's "fake shift" bytes, not modifiers.
        if (!is_ext && bus.i_code == 8'h12) begin
          shft_l_d = !is_brk;
        end else if (!is_ext && bus.i_code == 8'h59) begin
          shft_r_d = !is_brk;
        end else if (!is_ext && bus.i_code == 8'h58) begin
          if (is_brk) begin
            caps_held_d = 1'b0;
          end else begin
            // Typematic repeats of caps lock arrive with caps_held set.
            if (!caps_held_q) caps_d = !caps_q;
            caps_held_d = 1'b1;
          end
        end else begin
`ifdef PS2_REPEAT_FILTER_EN
          if (is_brk) begin
            if (filt_match) filt_vld_d = 1'b0;
          end else begin
            rep_hit     = filt_match;
            filt_vld_d  = 1'b1;
            filt_ext_d  = is_ext;
            filt_code_d = bus.i_code;
          end
`endif
          dec_vld_d  = !is_brk && tr[7] && !rep_hit;
          dec_char_d = tr[6:0];
        end
      end
    end
  end

  assign o_shft = shft_l_q | shft_r_q;
  assign o_caps = caps_q;

  // ------------------------------------------------------------------ fifo
  logic [6:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             fifo_full;
  logic             pop;
  logic             wr_en;

  assign fifo_full      = (count_q == CNT_W'(FIFO_DEPTH));
  assign bus.o_char_vld = (count_q != '0);
  assign pop            = bus.o_char_vld && bus.i_char_rdy;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr_en          = dec_vld_q && (!fifo_full || pop);
  assign ovf_d          = dec_vld_q && fifo_full && !pop;
  assign bus.o_char     = bus.o_char_vld ? CHAR_W'(mem_q[rd_ptr_q]) : '0;
  assign o_ovf          = ovf_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Depth is a power of two, so pointer overflow is the modulo wrap.
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (wr_en && !pop)      count_d = count_q + CNT_W'(1);
    else if (!wr_en && pop) count_d = count_q - CNT_W'(1);
  end

  // NOTE: storage is left without reset; the count and pointers alone decide
  // which entries are meaningful, so clearing the array buys nothing.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= dec_char_q;
  end

  // NOTE: all state flops update with non-blocking assignments so every flop
  // samples the values from before this edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      shft_l_q    <= 1'b0;
      shft_r_q    <= 1'b0;
      caps_q      <= 1'b0;
      caps_held_q <= 1'b0;
      dec_vld_q   <= 1'b0;
      dec_char_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
`ifdef PS2_REPEAT_FILTER_EN
      filt_vld_q  <= 1'b0;
      filt_ext_q  <= 1'b0;
      filt_code_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      shft_l_q    <= shft_l_d;
      shft_r_q    <= shft_r_d;
      caps_q      <= caps_d;
      caps_held_q <= caps_held_d;
      dec_vld_q   <= dec_vld_d;
      dec_char_q  <= dec_char_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
`ifdef PS2_REPEAT_FILTER_EN
      filt_vld_q  <= filt_vld_d;
      filt_ext_q  <= filt_ext_d;
      filt_code_q <= filt_code_d;
`endif
    end
  end

endmodule

// File: tb/tb_ps2_keycode_decoder.sv
// ---------------------------------------------------------------------------
// tb_ps2_keycode_decoder
//   Directed bench for ps2_keycode_decoder (FIFO_DEPTH = 4).  A table of
//   single-byte vectors covers prefixes, modifiers and translation; hand
//   sequences cover latency, reset mid-prefix, typematic repeat and overflow.
//   Inputs change on the falling edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_ps2_keycode_decoder;

  localparam int CHAR_W = 8;
  localparam int DEPTH  = 4;
`ifdef PS2_REPEAT_FILTER_EN
  localparam int REP_N  = 1;
`else
  localparam int REP_N  = 3;
`endif

  typedef struct {
    logic [7:0] code;
    logic       emit;
    logic [7:0] ch;
    logic       shft;
    logic       caps;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic shft;
  logic caps;
  logic ovf;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t vecs[$];

  ps2_keycode_decoder_if #(.CHAR_W(CHAR_W)) bus ();

  ps2_keycode_decoder #(
    .CHAR_W     (CHAR_W),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .bus    (bus),
    .o_shft (shft),
    .o_caps (caps),
    .o_ovf  (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [7:0] code, input logic emit, input logic [7:0] ch,
                     input logic s, input logic c);
    vec_t v;
    v.code = code; v.emit = emit; v.ch = ch; v.shft = s; v.caps = c;
    vecs.push_back(v);
  endtask

  // One-cycle strobe; returns on the falling edge just after the capture edge.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.i_code     = b;
    bus.i_code_vld = 1'b1;
    @(negedge clk);
    bus.i_code_vld = 1'b0;
  endtask

  task automatic pop_one();
    bus.i_char_rdy = 1'b1;
    @(negedge clk);
    bus.i_char_rdy = 1'b0;
  endtask

  initial begin
    logic [7:0] ovf_keys [5];
    logic [7:0] ovf_exp  [4];

    // ------------------------------------------------------------ table
    add(8'h1C, 1, 8'h61, 0, 0);
    add(8'hF0, 0, 8'h00, 0, 0);
    add(8'h1C, 0, 8'h00, 0, 0);
    add(8'h12, 0, 8'h00, 1, 0);
    add(8'h1C, 1, 8'h41, 1, 0);
    add(8'hF0, 0, 8'h00, 1, 0);
    add(8'h1C, 0, 8'h00, 1, 0);
    add(8'hF0, 0, 8'h00, 1, 0);
    add(8'h12, 0, 8'h00, 0, 0);
    add(8'h1C, 1, 8'h61, 0, 0);
    add(8'h58, 0, 8'h00, 0, 1);   // caps toggles on
    add(8'h58, 0, 8'h00, 0, 1);   // typematic: no toggle
    add(8'h58, 0, 8'h00, 0, 1);
    add(8'hF0, 0, 8'h00, 0, 1);
    add(8'h58, 0, 8'h00, 0, 1);   // release caps
    add(8'h15, 1, 8'h51, 0, 1);   // Q
    add(8'h16, 1, 8'h31, 0, 1);   // caps ignored for digits
    add(8'h12, 0, 8'h00, 1, 1);
    add(8'h15, 1, 8'h71, 1, 1);   // shift xor caps -> lower
    add(8'h16, 1, 8'h21, 1, 1);   // '!'
    add(8'h4E, 1, 8'h5F, 1, 1);   // '_'
    add(8'hF0, 0, 8'h00, 1, 1);
    add(8'h12, 0, 8'h00, 0, 1);
    add(8'h58, 0, 8'h00, 0, 0);   // caps toggles off
    add(8'hF0, 0, 8'h00, 0, 0);
    add(8'h58, 0, 8'h00, 0, 0);
    add(8'h59, 0, 8'h00, 1, 0);   // right shift
    add(8'h1E, 1, 8'h40, 1, 0);   // '@'
    add(8'hF0, 0, 8'h00, 1, 0);
    add(8'h59, 0, 8'h00, 0, 0);
    add(8'h29, 1, 8'h20, 0, 0);   // space
    add(8'h0E, 1, 8'h60, 0, 0);   // '`'
    add(8'h5D, 1, 8'h5C, 0, 0);   // '\'
    add(8'h66, 1, 8'h08, 0, 0);   // backspace
    add(8'hE0, 0, 8'h00, 0, 0);
    add(8'h5A, 1, 8'h0D, 0, 0);   // keypad enter
    add(8'hE0, 0, 8'h00, 0, 0);
    add(8'hF0, 0, 8'h00, 0, 0);
    add(8'h5A, 0, 8'h00, 0, 0);
    add(8'hE0, 0, 8'h00, 0, 0);
    add(8'h75, 0, 8'h00, 0, 0);   // extended arrow: nothing
    add(8'h77, 0, 8'h00, 0, 0);   // unmapped make
    add(8'hFA, 0, 8'h00, 0, 0);
    add(8'hAA, 0, 8'h00, 0, 0);
    add(8'h1C, 1, 8'h61, 0, 0);   // FSM back in IDLE
    add(8'hF0, 0, 8'h00, 0, 0);
    add(8'h1C, 0, 8'h00, 0, 0);

    bus.i_code     = 8'h00;
    bus.i_code_vld = 1'b0;
    bus.i_char_rdy = 1'b0;
    rst            = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // ------------------------------------------------------ reset state
    check("rst_char",     32'(bus.o_char),     32'h00);
    check("rst_char_vld", 32'(bus.o_char_vld), 32'h0);
    check("rst_shft",     32'(shft),           32'h0);
    check("rst_caps",     32'(caps),           32'h0);
    check("rst_ovf",      32'(ovf),            32'h0);

    // ---------------------------------------------------------- latency
    send_byte(8'h1C);
    check("lat_vld_edge_k",  32'(bus.o_char_vld), 32'h0);
    @(negedge clk);
    check("lat_vld_edge_k1", 32'(bus.o_char_vld), 32'h1);
    check("lat_char",        32'(bus.o_char),     32'h61);
    pop_one();
    check("lat_empty", 32'(bus.o_char_vld), 32'h0);
    send_byte(8'hF0);
    send_byte(8'h1C);

    // ------------------------------------------------------ table loop
    for (int i = 0; i < vecs.size(); i++) begin
      send_byte(vecs[i].code);
      @(negedge clk);
      check($sformatf("v%0d_vld", i),  32'(bus.o_char_vld), 32'(vecs[i].emit));
      check($sformatf("v%0d_char", i), 32'(bus.o_char),     32'(vecs[i].emit ? vecs[i].ch : 8'h00));
      check($sformatf("v%0d_shft", i), 32'(shft),           32'(vecs[i].shft));
      check($sformatf("v%0d_caps", i), 32'(caps),           32'(vecs[i].caps));
      if (bus.o_char_vld) pop_one();
    end

    // --------------------------------------- reset mid-sequence
    send_byte(8'h12);
    send_byte(8'h58);
    send_byte(8'hF0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_shft", 32'(shft),           32'h0);
    check("midrst_caps", 32'(caps),           32'h0);
    check("midrst_vld",  32'(bus.o_char_vld), 32'h0);
    send_byte(8'h1C);
    @(negedge clk);
    check("midrst_after_vld",  32'(bus.o_char_vld), 32'h1);
    check("midrst_after_char", 32'(bus.o_char),     32'h61);
    pop_one();
    send_byte(8'hF0);
    send_byte(8'h1C);

    // ------------------------------------------------ typematic repeat
    repeat (3) send_byte(8'h1C);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rep%0d_vld", i), 32'(bus.o_char_vld), 32'(i < REP_N));
      if (i < REP_N) begin
        check($sformatf("rep%0d_char", i), 32'(bus.o_char), 32'h61);
        pop_one();
      end
    end
    check("rep_empty", 32'(bus.o_char_vld), 32'h0);
    send_byte(8'hF0);
    send_byte(8'h1C);

    // -------------------------------------------------- overflow/drain
    ovf_keys[0] = 8'h1C; ovf_keys[1] = 8'h32; ovf_keys[2] = 8'h21;
    ovf_keys[3] = 8'h23; ovf_keys[4] = 8'h24;
    ovf_exp[0]  = 8'h61; ovf_exp[1]  = 8'h62; ovf_exp[2]  = 8'h63;
    ovf_exp[3]  = 8'h64;
    for (int i = 0; i < 5; i++) begin
      send_byte(ovf_keys[i]);
      @(negedge clk);
      check($sformatf("ovf_key%0d", i), 32'(ovf), 32'(i == 4));
    end
    @(negedge clk);
    check("ovf_pulse_end", 32'(ovf),            32'h0);
    check("ovf_head",      32'(bus.o_char),     32'h61);
    check("ovf_head_vld",  32'(bus.o_char_vld), 32'h1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain%0d_vld", i),  32'(bus.o_char_vld), 32'h1);
      check($sformatf("drain%0d_char", i), 32'(bus.o_char),     32'(ovf_exp[i]));
      pop_one();
    end
    check("drain_empty_vld",  32'(bus.o_char_vld), 32'h0);
    check("drain_empty_char", 32'(bus.o_char),     32'h00);
    pop_one();   // pop on empty has no effect
    check("pop_empty_vld", 32'(bus.o_char_vld), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
